wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/ariane_pkg.sv | 14 +
 rtl/wb_rr_picker.sv | 35 +++
 rtl/wb_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Slice of the core-wide ariane_pkg: scoreboard sizing and the writeback payload type.
package ariane_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  // One scoreboard writeback: destination entry, result and exception flag.
  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          data;
    logic                     ex;
  } wb_payload_t;

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin picker: first set valid bit at or above ptr_i, wrapping to 0.
module wb_rr_picker #(
  parameter  int unsigned NR_REQ = 4,
  localparam int unsigned PTR_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic [NR_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [NR_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]  idx_o,
  output logic              any_o
);

  int unsigned      cand;
  logic [PTR_W-1:0] cand_idx;

  // Scan NR_REQ candidates starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= NR_REQ) cand = cand - NR_REQ;
      cand_idx = PTR_W'(cand);
      if (!any_o && valid_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: NR_REQ functional units share one registered scoreboard
// writeback port with round-robin fairness and full-throughput handoff.
// Optional conflict counter enabled by defining WB_ARBITER_PERF_EN.
module wb_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NR_REQ     = 4,
  parameter int unsigned TRANS_ID_W = TRANS_ID_BITS,
  parameter int unsigned DATA_W     = XLEN
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NR_REQ-1:0]                    req_valid_i,
  output logic [NR_REQ-1:0]                    req_ready_o,
  input  logic [NR_REQ-1:0][TRANS_ID_W-1:0]    req_trans_id_i,
  input  logic [NR_REQ-1:0][DATA_W-1:0]        req_data_i,
  input  logic [NR_REQ-1:0]                    req_ex_i,
  output logic                                 wb_valid_o,
  input  logic                                 wb_ready_i,
  output logic [TRANS_ID_W-1:0]                wb_trans_id_o,
  output logic [DATA_W-1:0]                    wb_data_o,
  output logic                                 wb_ex_o
`ifdef WB_ARBITER_PERF_EN
  ,
  output logic [31:0]                          conflict_cnt_o
`endif
);

  localparam int unsigned PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [NR_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;
  logic              can_accept;
  logic              grant_en;
  logic              do_grant;
  logic [PTR_W-1:0]  ptr_next;

  wb_rr_picker #(.NR_REQ(NR_REQ)) u_picker (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Grant only when the output register is empty or draining, outside flush and reset.
  always_comb begin
    can_accept  = !wb_valid_o || wb_ready_i;
    grant_en    = can_accept && !flush_i && rst_ni;
    do_grant    = grant_en && pick_any;
    req_ready_o = grant_en ? pick_gnt : '0;
    ptr_next    = (pick_idx == PTR_W'(NR_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_valid_o    <= 1'b0;
      wb_trans_id_o <= '0;
      wb_data_o     <= '0;
      wb_ex_o       <= 1'b0;
      rr_ptr        <= '0;
    end else if (flush_i) begin
      wb_valid_o <= 1'b0;
    end else if (do_grant) begin
      wb_valid_o    <= 1'b1;
      wb_trans_id_o <= req_trans_id_i[pick_idx];
      wb_data_o     <= req_data_i[pick_idx];
      wb_ex_o       <= req_ex_i[pick_idx];
      rr_ptr        <= ptr_next;
    end else if (wb_ready_i) begin
      wb_valid_o <= 1'b0;
    end
  end

`ifdef WB_ARBITER_PERF_EN
  logic conflict;

  // A cycle counts as a conflict when any valid requester goes unserved.
  always_comb begin
    conflict = ($countones(req_valid_i) >= 2) || (|(req_valid_i & ~req_ready_o));
  end

  // Saturating conflict counter; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      conflict_cnt_o <= '0;
    end else if (conflict && (conflict_cnt_o != 32'hFFFF_FFFF)) begin
      conflict_cnt_o <= conflict_cnt_o + 32'd1;
    end
  end
`endif

endmodule
